mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port `Memory` instance between `NREQ` requesters (e.g. operand fetch and result write-back in the binary calculator). It accepts one request at a time over a valid/ready handshake and drives the memory's `din/addr/RW/valid` port. It returns a tagged response for every transaction: write acknowledge or registered read data. It sits between the calculator datapath units and the memory.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_rr_pick.sv | 50 +++++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package mem_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Response kind, reported on rsp_write; same encoding as the request direction.
  localparam logic RSP_KIND_WRITE = 1'b1;
  localparam logic RSP_KIND_READ  = 1'b0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and response bundle for mem_arbiter.
// The arbiter takes the master modport; the environment takes slave.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREQ  = 2,
  parameter int ID_W  = 3
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_rw;
  logic [NREQ*DEPTH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      mem_din;
  logic [DEPTH-1:0]      mem_addr;
  logic                  mem_rw;
  logic                  mem_valid;
  logic [WIDTH-1:0]      mem_dout;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_write;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  busy;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, mem_dout,
    output req_ready, mem_din, mem_addr, mem_rw, mem_valid,
           rsp_valid, rsp_id, rsp_write, rsp_rdata, busy
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, mem_dout,
    input  req_ready, mem_din, mem_addr, mem_rw, mem_valid,
           rsp_valid, rsp_id, rsp_write, rsp_rdata, busy
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational one-hot selector over NREQ valid bits.
// Round-robin from last_i+1 by default; lowest index wins under MEM_ARB_FIXED_PRIO_EN.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 3
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [ID_W-1:0] last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = ID_W'(i);
      end
    end
  end
`else
  // Walk the search order backwards so the nearest candidate after last_i is written last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int j;
      j = (int'(last_i) + k) % NREQ;
      if (valid_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end
`endif

  assign any_o = |valid_i;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between NREQ requesters, one transaction at a time.
// MEM_ARB_FIXED_PRIO_EN switches the selector to fixed priority; timing is unchanged.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREQ  = 2,
  parameter int ID_W  = 3
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic             rw_q;
  logic [DEPTH-1:0] addr_q;
  logic [WIDTH-1:0] din_q;
  logic [ID_W-1:0]  id_q;
  logic             mem_valid_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rdata_q;

  logic [NREQ-1:0]  pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [NREQ-1:0]  ready;
  logic             accept;
  int               sel;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid_i (bus.req_valid),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign sel = int'(pick_idx);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ready   = '0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        ready = pick_gnt;
        if (pick_any) begin
          accept  = 1'b1;
          last_d  = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = (rw_q == RSP_KIND_WRITE) ? RESP : RWAIT;
      RWAIT:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(NREQ - 1);
      rw_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      id_q        <= '0;
      mem_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_valid_q <= (state_d == ISSUE);
      rsp_valid_q <= (state_d == RESP);
      if (accept) begin
        rw_q    <= bus.req_rw[sel];
        addr_q  <= bus.req_addr[sel*DEPTH +: DEPTH];
        din_q   <= bus.req_wdata[sel*WIDTH +: WIDTH];
        id_q    <= pick_idx;
        rdata_q <= '0;
      end else if (state_q == RWAIT) begin
        // Memory only holds dout for the cycle after valid; grab it here.
        rdata_q <= bus.mem_dout;
      end
    end
  end

  assign bus.req_ready = reset ? '0 : ready;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_write = rw_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model with a shadow memory.
module tb_mem_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int NREQ  = 3;
  localparam int ID_W  = 3;

  logic clk = 1'b0;
  logic reset;
  logic seed;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .ID_W(ID_W)) bus ();

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: registered read, dout zero whenever valid was low.
  logic [WIDTH-1:0] mem [256];
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A50000 + 32'(i);
    end else if (bus.mem_valid && bus.mem_rw) begin
      mem[bus.mem_addr] <= bus.mem_din;
    end
    bus.mem_dout <= (bus.mem_valid && !bus.mem_rw) ? mem[bus.mem_addr] : '0;
  end

  // Transaction model: m_t = cycles since acceptance (0 = idle).
  logic [WIDTH-1:0] shadow [256];
  int               m_t;
  int               m_last;
  int               m_id;
  logic             m_rw;
  logic [DEPTH-1:0] m_addr;
  logic [WIDTH-1:0] m_wd;
  logic [WIDTH-1:0] m_rd;
  int               pick_now;

  function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  always_comb pick_now = model_pick(bus.req_valid, m_last);

  always @(posedge clk) begin
    if (seed) for (int i = 0; i < 256; i++) shadow[i] <= 32'hA5A50000 + 32'(i);
    if (reset) begin
      m_t    <= 0;
      m_last <= NREQ - 1;
    end else if (m_t == 0) begin
      if (pick_now >= 0) begin
        m_t    <= 1;
        m_last <= pick_now;
        m_id   <= pick_now;
        m_rw   <= bus.req_rw[pick_now];
        m_addr <= bus.req_addr[pick_now*DEPTH +: DEPTH];
        m_wd   <= bus.req_wdata[pick_now*WIDTH +: WIDTH];
        m_rd   <= bus.req_rw[pick_now] ? '0 : shadow[bus.req_addr[pick_now*DEPTH +: DEPTH]];
        if (bus.req_rw[pick_now])
          shadow[bus.req_addr[pick_now*DEPTH +: DEPTH]] <= bus.req_wdata[pick_now*WIDTH +: WIDTH];
      end
    end else if ((m_rw && m_t == 2) || (!m_rw && m_t == 3)) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle compare against the model.
  logic [NREQ-1:0] exp_rdy;
  logic            exp_rv;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_rdy = '0;
      if (m_t == 0 && !reset && pick_now >= 0) exp_rdy[pick_now] = 1'b1;
      exp_rv = (m_rw && m_t == 2) || (!m_rw && m_t == 3);
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("busy", 64'(bus.busy), 64'(m_t != 0));
      chk("mem_valid", 64'(bus.mem_valid), 64'(m_t == 1));
      if (m_t == 1) begin
        chk("mem_rw", 64'(bus.mem_rw), 64'(m_rw));
        chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        chk("mem_din", 64'(bus.mem_din), 64'(m_wd));
      end
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        chk("rsp_write", 64'(bus.rsp_write), 64'(m_rw));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rd));
      end
    end
  end

  // Event log used by the directed scenarios and the random driver.
  int              glog[$];
  int              rsp_cnt = 0;
  int              mv_cnt = 0;
  logic [NREQ-1:0] acc_seen = '0;
  always @(negedge clk) begin
    acc_seen = reset ? '0 : (bus.req_ready & bus.req_valid);
    for (int i = 0; i < NREQ; i++) if (acc_seen[i]) glog.push_back(i);
    if (bus.rsp_valid) rsp_cnt++;
    if (bus.mem_valid) mv_cnt++;
  end

  task automatic set_req(input int i, input logic rw, input logic [DEPTH-1:0] a,
                         input logic [WIDTH-1:0] d);
    bus.req_rw[i]                  = rw;
    bus.req_addr[i*DEPTH +: DEPTH] = a;
    bus.req_wdata[i*WIDTH +: WIDTH] = d;
    bus.req_valid[i]               = 1'b1;
  endtask

  task automatic wait_grant(input int i, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.req_ready[i]) begin ok = 1'b1; break; end
    end
    if (!ok) fail("grant_timeout");
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic txn(input int i, input logic rw, input logic [DEPTH-1:0] a,
                     input logic [WIDTH-1:0] d, output int lat,
                     output logic [WIDTH-1:0] rd, output int rid);
    int t0, n;
    bit ok;
    lat = -1; rd = '0; rid = -1;
    set_req(i, rw, a, d);
    wait_grant(i, ok);
    t0 = cyc;
    @(posedge clk); #1 bus.req_valid[i] = 1'b0;
    if (!ok) return;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 40);
    if (!bus.rsp_valid) begin fail("rsp_timeout"); return; end
    lat = cyc - t0;
    rd  = bus.rsp_rdata;
    rid = int'(bus.rsp_id);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin @(posedge clk); #1; n++; end
    if (bus.busy) fail("idle_timeout");
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_mem_valid"}, 64'(bus.mem_valid), 64'd0);
    chk({tag, "_mem_rw"},    64'(bus.mem_rw), 64'd0);
    chk({tag, "_mem_addr"},  64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_din"},   64'(bus.mem_din), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_id"},    64'(bus.rsp_id), 64'd0);
    chk({tag, "_rsp_write"}, 64'(bus.rsp_write), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy), 64'd0);
  endtask

  initial begin
    int lat, rid, base, mv0, rc, ones;
    logic [WIDTH-1:0] rd;
    bit ok;

    reset = 1'b1; seed = 1'b1;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    @(posedge clk); #1 seed = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk); #1 reset = 1'b0;

    // Single write then read.
    mv0 = mv_cnt;
    txn(0, 1'b1, 8'h05, 32'hDEADBEEF, lat, rd, rid);
    chk("wr_latency", 64'(lat), 64'd2);
    chk("wr_id", 64'(rid), 64'd0);
    txn(0, 1'b0, 8'h05, '0, lat, rd, rid);
    chk("rd_latency", 64'(lat), 64'd3);
    chk("rd_data", 64'(rd), 64'hDEADBEEF);
    chk("mem_valid_pulses", 64'(mv_cnt - mv0), 64'd2);

    // Address wrap: top and bottom of the address space stay distinct.
    txn(1, 1'b1, 8'hFF, 32'h11, lat, rd, rid);
    txn(0, 1'b1, 8'h00, 32'h22, lat, rd, rid);
    txn(2, 1'b0, 8'hFF, '0, lat, rd, rid);
    chk("wrap_ff_data", 64'(rd), 64'h11);
    chk("wrap_ff_id", 64'(rid), 64'd2);
    txn(2, 1'b0, 8'h00, '0, lat, rd, rid);
    chk("wrap_00_data", 64'(rd), 64'h22);

    // Contention: req0 and req1 continuously valid.
    base = glog.size();
    set_req(0, 1'b0, 8'h01, '0);
    set_req(1, 1'b0, 8'h02, '0);
    for (int n = 0; n < 100 && glog.size() < base + 6; n++) begin @(posedge clk); #1; end
    bus.req_valid = '0;
    if (glog.size() < base + 6) fail("contention_grants");
    else begin
      for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk("fixed_grant", 64'(glog[base + k]), 64'd0);
`else
        chk("rr_grant", 64'(glog[base + k]), 64'(k % 2));
`endif
      end
    end
    wait_idle();

    // Reset while a read is waiting for memory data.
    set_req(0, 1'b0, 8'h05, '0);
    wait_grant(0, ok);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("rwait_busy", 64'(bus.busy), 64'd1);
    rc = rsp_cnt;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("rwait_rst");
    repeat (4) @(posedge clk);
    #1 chk("rwait_no_rsp", 64'(rsp_cnt - rc), 64'd0);
    set_req(1, 1'b1, 8'h40, 32'h1111_0001);
    set_req(0, 1'b1, 8'h41, 32'h0000_0000);
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.req_ready), 64'b001);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    wait_grant(1, ok);
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    wait_idle();

    // Withdrawn request produces no transaction.
    base = glog.size();
    mv0 = mv_cnt;
    set_req(0, 1'b1, 8'h30, 32'hCAFE0030);
    wait_grant(0, ok);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    set_req(1, 1'b0, 8'h30, '0);
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("withdraw_busy", 64'(bus.busy), 64'd0);
    chk("withdraw_grants", 64'(glog.size() - base), 64'd1);
    chk("withdraw_mem_valid", 64'(mv_cnt - mv0), 64'd1);

    // Randomized traffic with occasional withdrawal and reset.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc_seen[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = 1'b0;
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                    $urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    reset = 1'b0;
    bus.req_valid = '0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
